// File: rtl/mac_rx_framer.sv
// mac_rx_framer: receive-side framer for the 10 Mb/s Ethernet MAC.
// Hunts for the SFD in the PLS bit stream and packs frame bits LSB-first into
// 32-bit words. Data words go to receive-buffer addresses 1..2**ADDR_W-1. The
// status/length word is written to address 0 after the frame ends. The buffer
// then belongs to the host, with rx_done held high, until rx_ack.
// Optional build macro RX_CRC_CHECK_EN adds a CRC-32 residue check.
// When the macro is not defined, the crc_err bit (word 0 bit 14) is always 0.
module mac_rx_framer #(
    parameter int ADDR_W    = 9,
    parameter int MIN_BYTES = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rx_dv,
    input  logic              rx_bit,
    input  logic              rx_bit_stb,
    input  logic              rx_ack,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [31:0]       buf_dat,
    output logic              rx_done,
    output logic [11:0]       rx_len,
    output logic              rx_missed
);

    typedef enum logic [2:0] {
        S_IDLE, S_HUNT, S_DATA, S_FLUSH1, S_FLUSH2, S_DONE, S_SKIP
    } state_t;

    localparam logic [15:0] MAX_ADDR = 16'((1 << ADDR_W) - 1);
    localparam logic [11:0] MIN_B    = 12'(MIN_BYTES);

    state_t              state_q, state_d;
    logic [14:0]         cnt_q, cnt_d;
    logic [31:0]         shift_q, shift_d;
    logic                prev_q, prev_d;
    logic                ovf_q, ovf_d;
    logic                dv_prev_q, dv_prev_d;
    logic                buf_we_q, buf_we_d;
    logic [ADDR_W-1:0]   buf_addr_q, buf_addr_d;
    logic [31:0]         buf_dat_q, buf_dat_d;
    logic                rx_done_q, rx_done_d;
    logic [11:0]         rx_len_q, rx_len_d;
    logic                rx_missed_q, rx_missed_d;

`ifdef RX_CRC_CHECK_EN
    logic [31:0]         crc_q, crc_d;
`endif

    // Helper values derived from the current bit count.
    logic [15:0] word_idx;
    logic [11:0] bytes;
    logic [31:0] shift_new;
    logic        runt, align_err, crc_err;

    // Next-state, buffer-write and status logic.
    // Buffer outputs are registered, so a write decided on one edge is visible for the whole following cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        prev_d      = prev_q;
        ovf_d       = ovf_q;
        dv_prev_d   = rx_dv;
        buf_we_d    = 1'b0;
        buf_addr_d  = buf_addr_q;
        buf_dat_d   = buf_dat_q;
        rx_done_d   = rx_done_q;
        rx_len_d    = rx_len_q;
        rx_missed_d = 1'b0;
`ifdef RX_CRC_CHECK_EN
        crc_d       = crc_q;
        crc_err     = (crc_q != 32'hDEBB20E3);
`else
        crc_err     = 1'b0;
`endif
        // The word index is taken from the count before it increments, so it
        // addresses the word that holds the current bit.
        word_idx  = 16'(cnt_q[14:5]) + 16'd1;
        bytes     = cnt_q[14:3];
        shift_new = shift_q | (32'(rx_bit) << cnt_q[4:0]);
        runt      = (bytes < MIN_B);
        align_err = |cnt_q[2:0];

        case (state_q)
            S_IDLE: begin
                prev_d = 1'b0;
                if (rx_dv) state_d = S_HUNT;
            end
            S_HUNT: begin
                if (!rx_dv) begin
                    state_d = S_IDLE;
                end else if (rx_bit_stb) begin
                    prev_d = rx_bit;
                    // Two consecutive 1 bits are the SFD tail; the frame starts with the next bit.
                    if (prev_q && rx_bit) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                        shift_d = '0;
                        ovf_d   = 1'b0;
`ifdef RX_CRC_CHECK_EN
                        crc_d   = 32'hFFFF_FFFF;
`endif
                    end
                end
            end
            S_DATA: begin
                if (rx_dv && rx_bit_stb) begin
                    // Saturate the count so a very long frame cannot wrap it.
                    if (cnt_q != 15'h7FFF) cnt_d = cnt_q + 15'd1;
`ifdef RX_CRC_CHECK_EN
                    crc_d = {1'b0, crc_q[31:1]} ^
                            ((crc_q[0] ^ rx_bit) ? 32'hEDB88320 : 32'h0);
`endif
                    if (cnt_q[4:0] == 5'd31) begin
                        shift_d = '0;
                        if (word_idx > MAX_ADDR) begin
                            ovf_d = 1'b1;
                        end else if (!ovf_q) begin
                            buf_we_d   = 1'b1;
                            buf_addr_d = word_idx[ADDR_W-1:0];
                            buf_dat_d  = shift_new;
                        end
                    end else begin
                        shift_d = shift_new;
                    end
                end else if (!rx_dv) begin
                    // The partial word is written in the first flush cycle.
                    state_d = S_FLUSH1;
                    if ((cnt_q[4:0] != 5'd0) && !ovf_q) begin
                        if (word_idx > MAX_ADDR) begin
                            ovf_d = 1'b1;
                        end else begin
                            buf_we_d   = 1'b1;
                            buf_addr_d = word_idx[ADDR_W-1:0];
                            buf_dat_d  = shift_q;
                        end
                    end
                end
            end
            S_FLUSH1: begin
                // The status word is written in the second flush cycle.
                state_d    = S_FLUSH2;
                buf_we_d   = 1'b1;
                buf_addr_d = '0;
                buf_dat_d  = {16'b0, runt, crc_err, align_err, ovf_q, bytes};
            end
            S_FLUSH2: begin
                state_d   = S_DONE;
                rx_done_d = 1'b1;
                rx_len_d  = bytes;
            end
            S_DONE: begin
                if (rx_dv && !dv_prev_q) rx_missed_d = 1'b1;
                if (rx_ack) begin
                    rx_done_d = 1'b0;
                    state_d   = rx_dv ? S_SKIP : S_IDLE;
                end
            end
            S_SKIP: begin
                if (!rx_dv) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            prev_q      <= 1'b0;
            ovf_q       <= 1'b0;
            dv_prev_q   <= 1'b0;
            buf_we_q    <= 1'b0;
            buf_addr_q  <= '0;
            buf_dat_q   <= '0;
            rx_done_q   <= 1'b0;
            rx_len_q    <= '0;
            rx_missed_q <= 1'b0;
`ifdef RX_CRC_CHECK_EN
            crc_q       <= 32'hFFFF_FFFF;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            prev_q      <= prev_d;
            ovf_q       <= ovf_d;
            dv_prev_q   <= dv_prev_d;
            buf_we_q    <= buf_we_d;
            buf_addr_q  <= buf_addr_d;
            buf_dat_q   <= buf_dat_d;
            rx_done_q   <= rx_done_d;
            rx_len_q    <= rx_len_d;
            rx_missed_q <= rx_missed_d;
`ifdef RX_CRC_CHECK_EN
            crc_q       <= crc_d;
`endif
        end
    end

    assign buf_we    = buf_we_q;
    assign buf_addr  = buf_addr_q;
    assign buf_dat   = buf_dat_q;
    assign rx_done   = rx_done_q;
    assign rx_len    = rx_len_q;
    assign rx_missed = rx_missed_q;

endmodule

// File: tb/tb_mac_rx_framer.sv
// tb_mac_rx_framer: directed bench for mac_rx_framer.
// A table of whole frames is applied, each with a hand-computed status word and length.
// Hand-written sequences then cover a missed frame, skipping after an ack, and a reset in mid-frame.
// Handshake: the bit stream is qualified by rx_dv, and each bit is one cycle of rx_bit_stb.
// The host releases the buffer with a one-cycle rx_ack while rx_done is high.
module tb_mac_rx_framer;

    localparam int ADDR_W = 9;
    localparam int NW     = 1 << ADDR_W;

    // Clock and reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_i      = 1'b1;
    logic              rx_dv      = 1'b0;
    logic              rx_bit     = 1'b0;
    logic              rx_bit_stb = 1'b0;
    logic              rx_ack     = 1'b0;
    logic              buf_we;
    logic [ADDR_W-1:0] buf_addr;
    logic [31:0]       buf_dat;
    logic              rx_done;
    logic [11:0]       rx_len;
    logic              rx_missed;

    mac_rx_framer #(.ADDR_W(ADDR_W), .MIN_BYTES(64)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .rx_dv      (rx_dv),
        .rx_bit     (rx_bit),
        .rx_bit_stb (rx_bit_stb),
        .rx_ack     (rx_ack),
        .buf_we     (buf_we),
        .buf_addr   (buf_addr),
        .buf_dat    (buf_dat),
        .rx_done    (rx_done),
        .rx_len     (rx_len),
        .rx_missed  (rx_missed)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard: a buffer image plus per-address write counts, captured mid-cycle.
    logic [31:0] mem    [0:NW-1];
    int          wr_cnt [0:NW-1];
    int          last_addr;
    int          missed_cnt;
    logic        mon_clr = 1'b0;

    always @(negedge clk) begin
        if (mon_clr) begin
            for (int a = 0; a < NW; a++) begin
                mem[a]    <= 32'h0;
                wr_cnt[a] <= 0;
            end
            last_addr  <= -1;
            missed_cnt <= 0;
        end else begin
            if (buf_we) begin
                mem[buf_addr]    <= buf_dat;
                wr_cnt[buf_addr] <= wr_cnt[buf_addr] + 1;
                last_addr        <= int'(buf_addr);
            end
            if (rx_missed) missed_cnt <= missed_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
    endtask

    // Frame model: the bits after the SFD, in order on the wire.
    logic fbit [0:17999];
    int   fbits_n;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic b);
        logic fb;
        fb = c[0] ^ b;
        crc_step = {1'b0, c[31:1]} ^ (fb ? 32'hEDB88320 : 32'h0);
    endfunction

    // Build random payload + correct FCS, then optional trailing dribble bits.
    task automatic build_frame(input int nbytes, input int extra);
        logic [31:0] c;
        logic [7:0]  b;
        int          n;
        c = 32'hFFFF_FFFF;
        n = 0;
        for (int i = 0; i < nbytes - 4; i++) begin
            b = 8'($urandom_range(0, 255));
            for (int j = 0; j < 8; j++) begin
                fbit[n] = b[j];
                c = crc_step(c, b[j]);
                n++;
            end
        end
        c = ~c;
        for (int j = 0; j < 32; j++) begin
            fbit[n] = c[j];
            n++;
        end
        for (int j = 0; j < extra; j++) begin
            fbit[n] = 1'($urandom_range(0, 1));
            n++;
        end
        fbits_n = n;
    endtask

    // Driver tasks
    task automatic strobe(input logic b);
        rx_bit     = b;
        rx_bit_stb = 1'b1;
        tick();
        rx_bit_stb = 1'b0;
        rx_bit     = 1'b0;
    endtask

    task automatic send_pre();
        logic [7:0] p;
        rx_dv = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            p = (k < 7) ? 8'h55 : 8'hD5;
            for (int j = 0; j < 8; j++) strobe(p[j]);
        end
    endtask

    // Sends model bits [from,to). An idle gap follows every 8th bit.
    // With drop set, rx_dv falls in the cycle right after the last strobe.
    task automatic send_bits(input int from, input int to, input bit drop);
        for (int i = from; i < to; i++) begin
            strobe(fbit[i]);
            if (i == to - 1 && drop) rx_dv = 1'b0;
            else if (i % 8 == 7) tick();
        end
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        tick();
        rx_ack = 1'b0;
    endtask

    // Sends one frame, then checks latency, the buffer image, the status word and the host handshake.
    task automatic run_frame(input string name, input int nbytes, input int extra,
                             input bit crc_bad, input logic [31:0] exp_w0_in,
                             input int exp_len, input bit do_ack);
        logic [31:0] exp_w0, ew;
        int          k, nw, extra_wr, idx;
        exp_w0 = exp_w0_in;
`ifdef RX_CRC_CHECK_EN
        if (crc_bad) exp_w0 = exp_w0 | 32'h4000;
`else
        if (crc_bad) exp_w0 = exp_w0_in;
`endif
        clear_mon();
        build_frame(nbytes, extra);
        send_pre();
        send_bits(0, fbits_n, 1'b1);
        k = 0;
        while (!rx_done && k < 20) begin
            tick();
            k++;
        end
        // rx_done rises 4 cycles after the last bit strobe; 20 cycles without it is a timeout.
        check({name, " latency"}, 32'(k), 32'd3);
        tick();
        check({name, " word0"}, mem[0], exp_w0);
        check({name, " word0 writes"}, 32'(wr_cnt[0]), 32'd1);
        check({name, " word0 last"}, 32'(last_addr), 32'd0);
        check({name, " rx_done"}, 32'(rx_done), 32'd1);
        check({name, " rx_len"}, 32'(rx_len), 32'(exp_len));
        nw = (fbits_n + 31) / 32;
        if (nw > NW - 1) nw = NW - 1;
        for (int w = 1; w <= nw; w++) begin
            ew = 32'h0;
            for (int j = 0; j < 32; j++) begin
                idx = (w - 1) * 32 + j;
                if (idx < fbits_n) ew[j] = fbit[idx];
            end
            check($sformatf("%s word%0d writes", name, w), 32'(wr_cnt[w]), 32'd1);
            check($sformatf("%s word%0d", name, w), mem[w], ew);
        end
        extra_wr = 0;
        for (int a = nw + 1; a < NW; a++) extra_wr += wr_cnt[a];
        check({name, " stray writes"}, 32'(extra_wr), 32'd0);
        if (do_ack) begin
            pulse_ack();
            check({name, " rx_done after ack"}, 32'(rx_done), 32'd0);
            tick();
        end
    endtask

    typedef struct {
        int          nbytes;
        int          extra;
        bit          crc_bad;
        logic [31:0] exp_w0;
        int          exp_len;
    } vec_t;

    vec_t vecs [6];

    initial begin
        // Bytes = frame bits / 8. Flags: runt b15, crc_err b14, align_err b13, ovf b12.
        vecs[0] = '{64,   0, 1'b0, 32'h0000_0040, 64};
        vecs[1] = '{61,   0, 1'b0, 32'h0000_803D, 61};
        vecs[2] = '{64,   3, 1'b1, 32'h0000_2040, 64};
        vecs[3] = '{10,   0, 1'b0, 32'h0000_800A, 10};
        vecs[4] = '{1500, 0, 1'b0, 32'h0000_05DC, 1500};
        vecs[5] = '{2100, 0, 1'b0, 32'h0000_1834, 2100};

        clear_mon();
        repeat (3) tick();
        check("reset buf_we", 32'(buf_we), 32'd0);
        check("reset buf_addr", 32'(buf_addr), 32'd0);
        check("reset buf_dat", buf_dat, 32'd0);
        check("reset rx_done", 32'(rx_done), 32'd0);
        check("reset rx_len", 32'(rx_len), 32'd0);
        check("reset rx_missed", 32'(rx_missed), 32'd0);
        rst_i = 1'b0;
        tick();

        // An ack while idle must be ignored.
        pulse_ack();
        check("idle ack rx_done", 32'(rx_done), 32'd0);

        for (int v = 0; v < 6; v++) begin
            run_frame($sformatf("vec%0d", v), vecs[v].nbytes, vecs[v].extra,
                      vecs[v].crc_bad, vecs[v].exp_w0, vecs[v].exp_len, 1'b1);
        end

        // A frame held in the buffer, then a second frame starts before the ack.
        run_frame("hold", 64, 0, 1'b0, 32'h0000_0040, 64, 1'b0);
        clear_mon();
        build_frame(64, 0);
        send_pre();
        send_bits(0, 40, 1'b0);
        check("missed rx_done held", 32'(rx_done), 32'd1);
        pulse_ack();
        check("skip rx_done", 32'(rx_done), 32'd0);
        send_bits(40, fbits_n, 1'b1);
        repeat (6) tick();
        check("missed pulses", 32'(missed_cnt), 32'd1);
        check("skip writes", 32'(wr_cnt[0] + wr_cnt[1] + wr_cnt[2]), 32'd0);
        check("skip rx_done idle", 32'(rx_done), 32'd0);
        run_frame("after_skip", 64, 0, 1'b0, 32'h0000_0040, 64, 1'b1);

        // Reset in mid-DATA abandons the frame without a status word.
        clear_mon();
        build_frame(64, 0);
        send_pre();
        send_bits(0, 100, 1'b0);
        rst_i = 1'b1;
        rx_dv = 1'b0;
        tick();
        check("midrst buf_we", 32'(buf_we), 32'd0);
        check("midrst buf_addr", 32'(buf_addr), 32'd0);
        check("midrst buf_dat", buf_dat, 32'd0);
        check("midrst rx_done", 32'(rx_done), 32'd0);
        check("midrst rx_len", 32'(rx_len), 32'd0);
        rst_i = 1'b0;
        repeat (8) tick();
        check("midrst word0 writes", 32'(wr_cnt[0]), 32'd0);
        run_frame("after_rst", 64, 0, 1'b0, 32'h0000_0040, 64, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_rx_framer.md
Name: mac_rx_framer

Overview:
- Receive-side framer for the 10 Mb/s Ethernet MAC.
- Consumes the decoded bit stream from the PLS receive path: carrier/data-valid plus one strobe per bit.
- Strips preamble/SFD and packs frame bits LSB-first into 32-bit words. Writes them into the MAC receive buffer through a single write port, with the status/length word at address 0.
- Mirrors the TX buffer layout: word 0 = length, data from word 1. Raises rx_done, which drives the rxfull interrupt, until the host acknowledges.

Parameters:
ADDR_W, 9, receive buffer word-address width; data capacity is 2**ADDR_W-1 words.
MIN_BYTES, 64, frames shorter than this many bytes are flagged runt.

Ports:
clk_i  in  1  system clock, all logic on rising edge
rst_i  in  1  synchronous active-high reset
rx_dv  in  1  carrier present / decoded data valid from PLS
rx_bit  in  1  decoded data bit, valid when rx_bit_stb=1
rx_bit_stb  in  1  one-cycle strobe per received bit; ignored when rx_dv=0
rx_ack  in  1  host releases buffer (one-cycle pulse)
buf_we  out  1  buffer write enable (one cycle per word)
buf_addr  out  ADDR_W  buffer word address
buf_dat  out  32  buffer write data
rx_done  out  1  frame stored, buffer owned by host
rx_len  out  12  byte count of last stored frame (valid while rx_done)
rx_missed  out  1  one-cycle pulse: frame start seen while rx_done=1

Behaviour:
- Reset values: buf_we=0, buf_addr=0, buf_dat=0, rx_done=0, rx_len=0, rx_missed=0, state=IDLE, bit counter=0, flags=0.
- States:
  - IDLE: rx_dv=1 -> HUNT.
  - HUNT: track the previous valid bit. Two consecutive 1 bits (the SFD tail "11") -> DATA with bit counter cleared. rx_dv=0 -> IDLE, no write.
  - DATA: per strobe, shift rx_bit into bit (cnt mod 32) of the shift word. cnt increments, 15 bits wide.
    - When cnt mod 32 reaches 31: next cycle buf_we=1, buf_addr=1+cnt/32, buf_dat=completed word; shift word cleared.
    - rx_dv=0 -> FLUSH.
  - FLUSH: two cycles.
    - Cycle 1: if cnt mod 32 != 0 and no overflow, write the partial word; unfilled upper bits are 0.
    - Cycle 2: write word 0 = {16'b0, runt[15], crc_err[14], align_err[13], ovf[12], bytes[11:0]}. Set rx_done=1 and rx_len=bytes on the following edge. -> DONE.
  - DONE: hold rx_done=1.
    - rx_ack -> rx_done=0 next cycle; -> SKIP if rx_dv=1, else IDLE.
    - rx_dv rising while in DONE -> rx_missed pulse for one cycle; buffer untouched.
  - SKIP: wait for rx_dv=0 -> IDLE. This prevents syncing mid-frame.
- bytes = cnt[14:3], saturated at 4095.
- align_err = (cnt[2:0] != 0).
- runt = (bytes < MIN_BYTES).
- Overflow: if a word write would target address > 2**ADDR_W-1, set ovf and suppress all further data writes. Keep counting bits until rx_dv=0. Word 0 is still written.
- Word write and a rx_dv fall in the same cycle: word write completes first, then FLUSH; no lost word.
- rx_ack outside DONE: ignored.
- rst_i at any time: immediate return to reset values. A partially written buffer is abandoned, and word 0 is not written.
- Latency: last-bit strobe to rx_done high = 4 cycles minimum (word write, FLUSH x2, flag).

Optional Feature:
RX_CRC_CHECK_EN
- Defined:
  - Reflected CRC-32 register, initialised to 0xFFFFFFFF on DATA entry.
  - Per data bit: fb = crc[0]^bit; crc = crc>>1; if fb, crc ^= 0xEDB88320. All bits including FCS are fed.
  - At FLUSH: crc_err = (crc != 0xDEBB20E3).
- Undefined: no CRC logic; bit 14 of word 0 is always 0.

Test Plan:
- 64-byte valid frame (7x0x55, 0xD5, 60 data bytes, correct FCS) -> words 1..16 written once each; word 0 = 0x00000040; rx_done=1, rx_len=64; crc_err=0 with RX_CRC_CHECK_EN.
- 61-byte frame (488 bits) -> 15 full words, word 16 holds 8 bits with upper 24 bits=0; word 0 = 0x0000803D (runt set).
- Frame of 64 bytes + 3 extra bits -> word 0 bit 13=1; bytes=64.
- 2100-byte frame with ADDR_W=9 -> no write beyond addr 511; word 0 bit 12=1, bytes=2100.
- Second frame during DONE -> rx_missed pulses once; buffer unchanged. rx_ack while rx_dv=1 -> SKIP, then the next full frame is received normally.
- rst_i asserted in mid-DATA -> all outputs at reset values the next cycle; no word-0 write; the following frame is received correctly.
